// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the SRAM-backed memory controller: bus widths and
// the one-hot controller state encoding.
package mem_sram_ctrl_pkg;

    localparam int BUS_WIDTH      = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int RAM_MASK_WIDTH = 4;

    // One-hot controller states
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_WAIT = 3'b010,
        S_RESP = 3'b100
    } ctrl_state_t;

endpackage

// File: rtl/mem_sram_ctrl_sram.sv
// Single-port synchronous SRAM with per-byte write enables. One-cycle read
// latency; a read during a write returns the old word. Contents are never
// reset.
module sram_1p_bmask
    import mem_sram_ctrl_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [AW-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [RAM_MASK_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-masked write and registered read on the single port
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < RAM_MASK_WIDTH; i++) begin
                    if (wmask[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Slave-side memory controller serving the shared memory bus from an on-chip
// SRAM. One transaction in flight; a new request may be accepted in the cycle
// the previous response is returned.
// Optional wait states are compiled in with the MEM_WAIT_EN macro, which adds
// the WAIT state and a 4-bit down-counter loaded from WAIT_CYCLES.
//
// Handshake: a request transfers on a cycle where mem_req && mem_addr_ok; the
// master holds mem_req and its payload until then. mem_data_ok is a one-cycle
// response pulse (reads and writes); mem_rdata is non-zero only with it.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BUS_WIDTH-1:0]      mem_address,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [RAM_MASK_WIDTH-1:0] mem_wmask,
    input  logic                      mem_req,
    input  logic                      mem_we,
    output logic                      mem_addr_ok,
    output logic                      mem_data_ok,
    output logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [2:0]                dbg_state
);

    localparam int AW = $clog2(DEPTH);

    ctrl_state_t           state;
    ctrl_state_t           state_next;
    logic                  accept;
    logic                  go_wait;    // accepted request needs wait states
    logic                  wait_done;  // last wait state is being spent
    logic                  rd_q;       // in-flight transaction is a read
    logic                  fresh_q;    // request was accepted last cycle
    logic [DATA_WIDTH-1:0] resp_q;
    logic [DATA_WIDTH-1:0] sram_q;
    logic [AW-1:0]         word_idx;

    assign accept   = mem_req && mem_addr_ok;
    // Byte offset and address bits above the SRAM size are dropped (aliasing)
    assign word_idx = mem_address[AW+1:2];

    logic unused_addr;
    assign unused_addr = ^{mem_address[BUS_WIDTH-1:AW+2], mem_address[1:0]};

`ifdef MEM_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [3:0] wait_cnt;

    // Wait-state down-counter, loaded on accept and counted in WAIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign go_wait   = (WAIT_LOAD != 4'd0);
    assign wait_done = (wait_cnt == 4'd1);
`else
    logic unused_wait;
    assign unused_wait = ^4'(WAIT_CYCLES);
    assign go_wait     = 1'b0;
    assign wait_done   = 1'b1;
`endif

    sram_1p_bmask #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (accept),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (mem_wdata),
        .wmask (mem_wmask),
        .rdata (sram_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_next = go_wait ? S_WAIT : S_RESP;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_next = S_RESP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Response bookkeeping: transaction type and SRAM word held through wait states
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            fresh_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            fresh_q <= accept;
            if (accept) begin
                rd_q <= !mem_we;
            end
            if (fresh_q) begin
                resp_q <= sram_q;
            end
        end
    end

    // Outputs: addr_ok from state and reset, response from registered state only
    always_comb begin
        mem_addr_ok = rst_n && ((state == S_IDLE) || (state == S_RESP));
        mem_data_ok = (state == S_RESP);
        mem_rdata   = '0;
        if ((state == S_RESP) && rd_q) begin
            mem_rdata = fresh_q ? sram_q : resp_q;
        end
        dbg_state   = state;
    end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Slave-side memory controller that terminates the shared memory bus produced by the ROM/RAM arbiter: it accepts `mem_req` transactions via the `addr_ok`/`data_ok` handshake and services them from an on-chip single-port synchronous SRAM with byte-write masks. It supports one transaction in flight. A new request is accepted in the same cycle the previous response is returned, so back-to-back traffic runs at one transaction per cycle. Optional wait states can be compiled in to emulate slower memory.

## Interface
- `DEPTH`, 4096: SRAM depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 2: extra response latency, range 0..15. Used only when `MEM_WAIT_EN` is defined.
- `clk` input 1: clock. Reset is `rst_n`: synchronous, active-low; clock `clk`.
- `rst_n` input 1: synchronous active-low reset.
- `mem_address` input `BUS_WIDTH`: byte address.
- `mem_wdata` input `DATA_WIDTH`: write data.
- `mem_wmask` input `RAM_MASK_WIDTH`: byte enables; bit i enables byte i (`wdata[8i+7:8i]`).
- `mem_req` input 1: request valid.
- `mem_we` input 1: 1 = write, 0 = read.
- `mem_addr_ok` output 1: request accepted this cycle when `mem_req` is also high.
- `mem_data_ok` output 1: one-cycle response pulse; asserted for both reads and writes.
- `mem_rdata` output `DATA_WIDTH`: read data, valid only while `mem_data_ok` is high; 0 otherwise.

## Operation
- **States:**
  - IDLE: `mem_addr_ok` = 1.
  - WAIT: counting down wait states; `mem_addr_ok` = 0.
  - RESP: `mem_data_ok` = 1; `mem_addr_ok` = 1.
- **Accept:** a request is accepted when `mem_req && mem_addr_ok`. The address, we, wdata and wmask are applied to the SRAM in the accept cycle.
- **Transitions:**
  - IDLE → RESP on accept when the wait count is 0; IDLE → WAIT on accept when it is non-zero; otherwise stay in IDLE.
  - WAIT → RESP when the counter reaches 1.
  - RESP → RESP on accept with zero wait; RESP → WAIT on accept with non-zero wait; RESP → IDLE with no accept.
- **Addressing:** word index = `mem_address[log2(DEPTH)+1:2]`.
  - Bits [1:0] are ignored (no misalignment fault).
  - Upper bits are ignored, so addresses wrap and alias modulo `DEPTH*4`.
- **Writes:** bytes with mask bit 1 are updated at the end of the accept cycle. Mask 0000 leaves memory unchanged but still produces `mem_data_ok`. `mem_rdata` = 0 in the write's RESP cycle.
- **Reads:** the SRAM output is captured into a response register so that it stays stable through wait states. It is driven on `mem_rdata` only in RESP.
- **Read after write:** a write accepted in cycle T followed by a read of the same word accepted in T+1 returns the new data.
- **Mid-operation reset:** an in-flight transaction is discarded and no `mem_data_ok` is issued. SRAM contents are not cleared by reset.
- `mem_req` with `mem_addr_ok` = 0 is ignored. The master holds the request until accepted; the controller does not latch it.

## Timing
- **Reset values:** state IDLE, wait counter 0, response register 0. `mem_data_ok` = 0 and `mem_rdata` = 0. `mem_addr_ok` = 0 while `rst_n` = 0, and 1 from the first cycle after reset.
- **Latency:** accept in cycle T produces `mem_data_ok` in cycle T+1+W. W = `WAIT_CYCLES` with `MEM_WAIT_EN` defined, else 0.
- **Throughput:** with W = 0, one transaction per cycle. With W > 0, one transaction per W+1 cycles.
- **Outputs:** `mem_addr_ok` is combinational from state and `rst_n`. `mem_data_ok` and `mem_rdata` are derived from registered state only, with no combinational path from inputs.

## Configuration
- **`MEM_WAIT_EN` defined:** the WAIT state and a 4-bit down-counter are present, and `WAIT_CYCLES` sets the latency. `WAIT_CYCLES` = 0 behaves identically to the undefined case.
- **`MEM_WAIT_EN` undefined:** the WAIT state and counter are removed, latency is fixed at 1 cycle, and `WAIT_CYCLES` is ignored.

## Structure
- **Shared include/package:** `BUS_WIDTH` (32), `DATA_WIDTH` (32), `RAM_MASK_WIDTH` (4), and the controller state encodings (one-hot 3-bit: IDLE = 001, WAIT = 010, RESP = 100).
- **Sub-module `sram_1p_bmask`:** parameterised by `DEPTH`. Single-port, synchronous 1-cycle read, per-byte write enable, read-during-write returns old data. The controller never reads and writes the same port in one cycle.

## Test plan
1. **Reset:** hold `rst_n` = 0 for 3 cycles with `mem_req` = 1 → `mem_addr_ok` = 0 and `mem_data_ok` = 0 throughout. `mem_addr_ok` = 1 in the first cycle after release.
2. **Masked write and read back:**
   - Write 0x11223344 to 0x100 with mask 1111, then write 0xAABBCCDD to 0x100 with mask 0101.
   - Read 0x100 → `mem_rdata` = 0x11BB33DD, with `mem_data_ok` one cycle after the read is accepted (W = 0).
3. **Back-to-back traffic:**
   - Sequence: write 0xDEADBEEF to 0x40, then immediately read 0x40, then read 0x44 (previously 0).
   - Expect three `data_ok` pulses on consecutive cycles, with rdata 0, 0xDEADBEEF, 0.
4. **Wrap-around:** with `DEPTH` = 4096, write 0x5A5A5A5A to 0x4000, then read 0x0000 → 0x5A5A5A5A. Read 0x0003 also returns 0x5A5A5A5A (low bits ignored).
5. **Wait states:** with `MEM_WAIT_EN` and `WAIT_CYCLES` = 3, accept a read at T → `mem_addr_ok` = 0 for T+1..T+3, `mem_data_ok` at T+4, and a second request is accepted at T+4.
6. **Mid-operation reset:** with W = 3, accept a read at T and assert `rst_n` = 0 at T+2 → no `mem_data_ok` ever appears for that read. A subsequent read of the same word returns its pre-reset contents.
